op_stack_unit: RTL and testbench

Parametrised operand-stack engine for the multicycle stack-machine datapath. It holds a LIFO of WIDTH-bit entries and executes stack commands (push, pop, dup, swap) and stack-to-stack ALU operations (add, sub, and) in place, under a valid/ready command handshake. It flags overflow and underflow, and exposes top-of-stack, depth, zero and carry to the controller for branch decisions. It replaces the separate stack plus ALU result path of the previous datapath generation.

---
 rtl/op_stack_unit.sv | 204 ++++++++++++++++++++
 tb/tb_op_stack_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_stack_unit.sv
// op_stack_unit: LIFO operand stack with in-place stack commands
// (PUSH/POP/DUP/SWAP) and stack-to-stack ALU ops (ADD/SUB/AND).
// Single-cycle commands commit on the acceptance edge. DUP, SWAP and the
// ALU ops latch their operands on acceptance and commit one edge later,
// in EXEC. Optional feature macro: OP_STACK_PEEK_EN adds a combinational
// peek port that reads any entry counted from the top.
module op_stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_data,
    input  logic                     clr_err,
`ifdef OP_STACK_PEEK_EN
    input  logic [$clog2(DEPTH)-1:0] peek_idx,
    output logic [WIDTH-1:0]         peek_data,
`endif
    output logic [WIDTH-1:0]         tos_out,
    output logic [$clog2(DEPTH):0]   depth_out,
    output logic                     zero,
    output logic                     carry,
    output logic                     err_overflow,
    output logic                     err_underflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_AND  = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic [0:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic             r_err_ovf;
    logic             r_err_udf;

    logic             w_idle;
    logic             w_accept;
    logic             w_empty;
    logic             w_full;
    logic             w_lt2;
    logic [AW-1:0]    w_idx_sp;
    logic [AW-1:0]    w_idx_top;
    logic [AW-1:0]    w_idx_2nd;
    logic             w_push;
    logic             w_pop;
    logic             w_start_multi;
    logic             w_set_ovf;
    logic             w_set_udf;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_tos;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && w_idle;
    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SPW'(DEPTH));
    assign w_lt2     = (r_sp < SPW'(2));
    // Indices wrap modulo DEPTH; they are only used when the access is legal.
    assign w_idx_sp  = r_sp[AW-1:0];
    assign w_idx_top = r_sp[AW-1:0] - AW'(1);
    assign w_idx_2nd = r_sp[AW-1:0] - AW'(2);

    // Decode the accepted command into its legal action or an error flag.
    always_comb begin
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_start_multi = 1'b0;
        w_set_ovf     = 1'b0;
        w_set_udf     = 1'b0;
        if (w_accept) begin
            case (cmd_op)
                OP_PUSH: begin
                    if (w_full) w_set_ovf = 1'b1;
                    else        w_push    = 1'b1;
                end
                OP_POP: begin
                    if (w_empty) w_set_udf = 1'b1;
                    else         w_pop     = 1'b1;
                end
                OP_DUP: begin
                    // Underflow takes precedence over overflow.
                    if (w_empty)     w_set_udf     = 1'b1;
                    else if (w_full) w_set_ovf     = 1'b1;
                    else             w_start_multi = 1'b1;
                end
                OP_SWAP, OP_ADD, OP_SUB, OP_AND: begin
                    if (w_lt2) w_set_udf     = 1'b1;
                    else       w_start_multi = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ALU on the latched operands; bit WIDTH of the difference is the borrow.
    assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

    // Select the EXEC result written back to the second entry.
    always_comb begin
        case (r_op)
            OP_ADD:  w_alu_res = w_sum[WIDTH-1:0];
            OP_SUB:  w_alu_res = w_diff[WIDTH-1:0];
            default: w_alu_res = r_opa & r_opb;
        endcase
    end

    // Control state: FSM, stack pointer, operand latches, carry, error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sp      <= '0;
            r_op      <= OP_NOP;
            r_opa     <= '0;
            r_opb     <= '0;
            r_carry   <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            // Sticky flags: a new error wins over a simultaneous clear.
            r_err_ovf <= w_set_ovf | (r_err_ovf & ~clr_err);
            r_err_udf <= w_set_udf | (r_err_udf & ~clr_err);
            if (r_state == ST_IDLE) begin
                if (w_push) r_sp <= r_sp + SPW'(1);
                if (w_pop)  r_sp <= r_sp - SPW'(1);
                if (w_start_multi) begin
                    r_op    <= cmd_op;
                    r_opa   <= r_mem[w_idx_2nd];
                    r_opb   <= r_mem[w_idx_top];
                    r_state <= ST_EXEC;
                end
            end else begin
                case (r_op)
                    OP_DUP: r_sp <= r_sp + SPW'(1);
                    OP_ADD: begin
                        r_sp    <= r_sp - SPW'(1);
                        r_carry <= w_sum[WIDTH];
                    end
                    OP_SUB: begin
                        r_sp    <= r_sp - SPW'(1);
                        r_carry <= w_diff[WIDTH];
                    end
                    OP_AND: r_sp <= r_sp - SPW'(1);
                    default: ;
                endcase
                r_state <= ST_IDLE;
            end
        end
    end

    // Entry storage: PUSH writes in IDLE, multi-cycle ops write back in EXEC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push) r_mem[w_idx_sp] <= cmd_data;
            if (r_state == ST_EXEC) begin
                case (r_op)
                    OP_DUP: r_mem[w_idx_sp] <= r_opb;
                    OP_SWAP: begin
                        r_mem[w_idx_2nd] <= r_opb;
                        r_mem[w_idx_top] <= r_opa;
                    end
                    OP_ADD, OP_SUB, OP_AND: r_mem[w_idx_2nd] <= w_alu_res;
                    default: ;
                endcase
            end
        end
    end

    assign w_tos         = w_empty ? '0 : r_mem[w_idx_top];
    assign tos_out       = w_tos;
    assign depth_out     = r_sp;
    assign zero          = (w_tos == '0);
    assign carry         = r_carry;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_udf;
    assign cmd_ready     = w_idle;

`ifdef OP_STACK_PEEK_EN
    logic [AW-1:0] w_peek_pos;
    assign w_peek_pos = r_sp[AW-1:0] - AW'(1) - peek_idx;
    assign peek_data  = ({1'b0, peek_idx} >= r_sp) ? '0 : r_mem[w_peek_pos];
`endif

endmodule

// File: tb/tb_op_stack_unit.sv
// Bench for op_stack_unit (WIDTH=8, DEPTH=4): directed vector tables,
// a reset-during-EXEC sequence, then random commands against a queue model.
module tb_op_stack_unit;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       clr_err;
    logic [7:0] tos_out;
    logic [2:0] depth_out;
    logic       zero;
    logic       carry;
    logic       err_overflow;
    logic       err_underflow;
`ifdef OP_STACK_PEEK_EN
    logic [1:0] peek_idx;
    logic [7:0] peek_data;
`endif

    int total = 0;
    int bad   = 0;

    op_stack_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .clr_err      (clr_err),
`ifdef OP_STACK_PEEK_EN
        .peek_idx     (peek_idx),
        .peek_data    (peek_data),
`endif
        .tos_out      (tos_out),
        .depth_out    (depth_out),
        .zero         (zero),
        .carry        (carry),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic       clr;
        logic [7:0] tos;
        int         depth;
        logic       carry;
        logic       ovf;
        logic       udf;
        int         cyc;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: a queue whose last element is the top of stack.
    int   mq[$];
    logic m_carry, m_ovf, m_udf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic [2:0] op, input logic [7:0] data, input logic clr,
                        input logic [7:0] tos, input int depth, input logic c,
                        input logic o, input logic u, input int cyc);
        vec_t v;
        v.op = op; v.data = data; v.clr = clr; v.tos = tos; v.depth = depth;
        v.carry = c; v.ovf = o; v.udf = u; v.cyc = cyc;
        tbl.push_back(v);
    endtask

    // Present one command at posedge+1, then wait (bounded) for ready again.
    task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic clr,
                         output int cyc);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; clr_err = clr;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0; clr_err = 1'b0;
        cyc = 0;
        while (!cmd_ready && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] tos, input int depth,
                             input logic c, input logic o, input logic u);
        chk({tag, ".tos"},   tos_out, tos);
        chk({tag, ".depth"}, depth_out, depth);
        chk({tag, ".zero"},  zero, (tos == 8'd0));
        chk({tag, ".carry"}, carry, c);
        chk({tag, ".ovf"},   err_overflow, o);
        chk({tag, ".udf"},   err_underflow, u);
        chk({tag, ".ready"}, cmd_ready, 1'b1);
    endtask

    task automatic run_tbl(input string tag);
        int cyc;
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i].op, tbl[i].data, tbl[i].clr, cyc);
            $display("%s[%0d] op=%0d data=%h tos=%h depth=%0d carry=%0b ovf=%0b udf=%0b busy=%0d",
                     tag, i, tbl[i].op, tbl[i].data, tos_out, depth_out, carry,
                     err_overflow, err_underflow, cyc);
            chk($sformatf("%s[%0d].busy", tag, i), cyc, tbl[i].cyc);
            chk_state($sformatf("%s[%0d]", tag, i), tbl[i].tos, tbl[i].depth,
                      tbl[i].carry, tbl[i].ovf, tbl[i].udf);
        end
        tbl.delete();
    endtask

    // Apply one command to the model; returns the expected busy cycles.
    task automatic model(input int op, input int data, input logic clr, output int cyc_exp);
        int n, a, b, r;
        logic so, su;
        n = mq.size(); so = 0; su = 0; cyc_exp = 0;
        case (op)
            1: if (n == 4) so = 1; else mq.push_back(data);
            2: if (n == 0) su = 1; else void'(mq.pop_back());
            3: if (n == 0) su = 1; else if (n == 4) so = 1;
               else begin mq.push_back(mq[n-1]); cyc_exp = 1; end
            4: if (n < 2) su = 1;
               else begin a = mq[n-2]; mq[n-2] = mq[n-1]; mq[n-1] = a; cyc_exp = 1; end
            5, 6, 7: if (n < 2) su = 1;
               else begin
                   b = mq.pop_back(); a = mq.pop_back();
                   if (op == 5) begin r = (a + b) % 256; m_carry = (a + b) > 255; end
                   else if (op == 6) begin r = (a - b + 256) % 256; m_carry = (a < b); end
                   else r = a & b;
                   mq.push_back(r);
                   cyc_exp = 1;
               end
            default: ;
        endcase
        if (clr) begin m_ovf = 0; m_udf = 0; end
        if (so) m_ovf = 1;
        if (su) m_udf = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, cexp, op, dat;
        logic clr;
        logic [7:0] etos;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0; clr_err = 1'b0;
`ifdef OP_STACK_PEEK_EN
        peek_idx = 2'd0;
`endif
        // Commands during reset must be ignored.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h55;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0;
        chk_state("reset", 8'h00, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Arithmetic, overflow, underflow, SWAP/DUP scenarios.
        addv(3'd1, 8'h05, 0, 8'h05, 1, 0, 0, 0, 0);
        addv(3'd1, 8'h03, 0, 8'h03, 2, 0, 0, 0, 0);
        addv(3'd5, 8'h00, 0, 8'h08, 1, 0, 0, 0, 1);
        addv(3'd1, 8'hF0, 0, 8'hF0, 2, 0, 0, 0, 0);
        addv(3'd1, 8'h20, 0, 8'h20, 3, 0, 0, 0, 0);
        addv(3'd5, 8'h00, 0, 8'h10, 2, 1, 0, 0, 1);
        addv(3'd1, 8'h11, 0, 8'h11, 3, 1, 0, 0, 0);
        addv(3'd6, 8'h00, 0, 8'hFF, 2, 1, 0, 0, 1);
        addv(3'd2, 8'h00, 0, 8'h08, 1, 1, 0, 0, 0);
        addv(3'd2, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
        addv(3'd1, 8'h01, 0, 8'h01, 1, 1, 0, 0, 0);
        addv(3'd1, 8'h02, 0, 8'h02, 2, 1, 0, 0, 0);
        addv(3'd1, 8'h03, 0, 8'h03, 3, 1, 0, 0, 0);
        addv(3'd1, 8'h04, 0, 8'h04, 4, 1, 0, 0, 0);
        addv(3'd1, 8'h09, 0, 8'h04, 4, 1, 1, 0, 0);
        addv(3'd0, 8'h00, 1, 8'h04, 4, 1, 0, 0, 0);
        addv(3'd2, 8'h00, 0, 8'h03, 3, 1, 0, 0, 0);
        addv(3'd2, 8'h00, 0, 8'h02, 2, 1, 0, 0, 0);
        addv(3'd2, 8'h00, 0, 8'h01, 1, 1, 0, 0, 0);
        addv(3'd2, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
        addv(3'd2, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0);
        addv(3'd1, 8'h07, 0, 8'h07, 1, 1, 0, 1, 0);
        addv(3'd4, 8'h00, 0, 8'h07, 1, 1, 0, 1, 0);
        addv(3'd2, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0);
        addv(3'd0, 8'h00, 1, 8'h00, 0, 1, 0, 0, 0);
        addv(3'd1, 8'h0A, 0, 8'h0A, 1, 1, 0, 0, 0);
        addv(3'd1, 8'h0B, 0, 8'h0B, 2, 1, 0, 0, 0);
        addv(3'd4, 8'h00, 0, 8'h0A, 2, 1, 0, 0, 1);
        addv(3'd3, 8'h00, 0, 8'h0A, 3, 1, 0, 0, 1);
        run_tbl("vecA");

`ifdef OP_STACK_PEEK_EN
        peek_idx = 2'd0; #1; chk("peek0", peek_data, 8'h0A);
        peek_idx = 2'd1; #1; chk("peek1", peek_data, 8'h0A);
        peek_idx = 2'd2; #1; chk("peek2", peek_data, 8'h0B);
        peek_idx = 2'd3; #1; chk("peek3", peek_data, 8'h00);
        peek_idx = 2'd0;
`endif

        // Entries below the top, SUB without borrow, AND, DUP at full.
        addv(3'd2, 8'h00, 0, 8'h0A, 2, 1, 0, 0, 0);
        addv(3'd2, 8'h00, 0, 8'h0B, 1, 1, 0, 0, 0);
        addv(3'd1, 8'h01, 0, 8'h01, 2, 1, 0, 0, 0);
        addv(3'd6, 8'h00, 0, 8'h0A, 1, 0, 0, 0, 1);
        addv(3'd1, 8'h0F, 0, 8'h0F, 2, 0, 0, 0, 0);
        addv(3'd7, 8'h00, 0, 8'h0A, 1, 0, 0, 0, 1);
        addv(3'd1, 8'h01, 0, 8'h01, 2, 0, 0, 0, 0);
        addv(3'd1, 8'h02, 0, 8'h02, 3, 0, 0, 0, 0);
        addv(3'd1, 8'h03, 0, 8'h03, 4, 0, 0, 0, 0);
        addv(3'd3, 8'h00, 0, 8'h03, 4, 0, 1, 0, 0);
        run_tbl("vecB");

        // Reset during the EXEC cycle of an ADD aborts it immediately.
        cmd_valid = 1'b1; cmd_op = 3'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0;
        chk("exec.ready_low", cmd_ready, 1'b0);
        rst = 1'b1; #1;
        $display("rst-in-exec depth=%0d ready=%0b", depth_out, cmd_ready);
        chk("rstexec.depth", depth_out, 0);
        chk("rstexec.ready", cmd_ready, 1'b1);
        chk("rstexec.tos", tos_out, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(3'd1, 8'h01, 1'b0, cyc);
        $display("post-reset push tos=%h depth=%0d", tos_out, depth_out);
        chk_state("postrst", 8'h01, 1, 1'b0, 1'b0, 1'b0);

        // Random commands against the queue model.
        mq.delete(); mq.push_back(1);
        m_carry = 0; m_ovf = 0; m_udf = 0;
        for (int i = 0; i < 200; i++) begin
            op  = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) op = 1;
            dat = $urandom_range(0, 255);
            clr = ($urandom_range(0, 7) == 0);
            model(op, dat, clr, cexp);
            issue(3'(op), 8'(dat), clr, cyc);
            etos = (mq.size() > 0) ? 8'(mq[mq.size()-1]) : 8'h00;
            $display("rnd[%0d] op=%0d data=%h clr=%0b tos=%h depth=%0d carry=%0b ovf=%0b udf=%0b",
                     i, op, dat, clr, tos_out, depth_out, carry, err_overflow, err_underflow);
            chk($sformatf("rnd[%0d].busy", i), cyc, cexp);
            chk_state($sformatf("rnd[%0d]", i), etos, mq.size(), m_carry, m_ovf, m_udf);
`ifdef OP_STACK_PEEK_EN
            peek_idx = 2'($urandom_range(0, 3)); #1;
            chk($sformatf("rnd[%0d].peek", i), peek_data,
                (int'(peek_idx) < mq.size()) ? 8'(mq[mq.size()-1-int'(peek_idx)]) : 8'h00);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
